sub_bytes_seq: RTL and testbench
================================

Name: sub_bytes_seq

Overview:
- Sequential, parametrised SubBytes engine for the AES-128 datapath.
- Applies the forward or inverse AES S-box to a 128-bit state. It processes LANES bytes per cycle, so designers can trade area (S-box count) against latency.
- Uses valid/ready handshakes on input and output so it can sit between the round-key/shift-rows stages and a stalling downstream consumer.
- Supports both encryption and decryption rounds, selected per block.

Parameters:
- LANES, 4, S-box instances used in parallel; legal values 1, 2, 4, 8, 16 (any other value is an elaboration error).
- NBYTES, 16, bytes per state; fixed constant, not overridable.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state/in_inv are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  state to substitute; byte i = bits [8i+7:8i].
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  substituted state.
- busy  output  1  high in BUSY state (status/debug).

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: state machine = IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, byte counter=0, latched mode=0.
- Handshakes: input transfer on in_valid & in_ready at a rising edge; output transfer on out_valid & out_ready.
- N = NBYTES/LANES processing cycles per block; counter width = clog2(N), minimum 1 bit.
- IDLE state:
  - in_ready=1.
  - On transfer: copy in_state to a working register, latch in_inv into the mode register, set counter=0, go to BUSY.
- BUSY state:
  - in_ready=0, busy=1.
  - Each cycle, bytes [counter*LANES .. counter*LANES+LANES-1] of the working register are replaced by their S-box image; byte 0 (LSB) is done first.
  - Mode is the latched value; in_inv changes during BUSY are ignored.
  - On the edge where counter = N-1: write the final group, load the result into out_state, set out_valid=1, go to DONE; otherwise counter increments.
- DONE state:
  - out_valid=1; out_state is held stable until the output transfer.
  - in_ready = out_ready (simultaneous handoff).
  - If out_ready & in_valid: complete the output transfer and accept the new block in the same edge; go to BUSY and clear out_valid.
  - If out_ready & !in_valid: go to IDLE and clear out_valid.
  - If !out_ready: stay in DONE with everything held.
- Latency: input accepted at edge t -> out_valid high after edge t+N. For LANES=16, N=1, so out_valid is high one cycle after acceptance.
- Throughput: one block per N+1 cycles when back-to-back.
- Reset mid-operation: rst in any state returns to reset values on the next edge; the partial block is discarded with no output.
- in_state is sampled only at transfer; later changes have no effect.
- S-box lookup is purely combinational. The working register is the only storage per byte (no separate input copy).

Decomposition:
- Package aes_pkg holds:
  - NBYTES = 16;
  - the 256-entry forward S-box table and 256-entry inverse S-box table as constant arrays;
  - a state-machine enum {IDLE, BUSY, DONE}.
- Sub-module sbox_lut: combinational, 8-bit in, 1-bit inv, 8-bit out, indexed from the aes_pkg tables; instantiated LANES times via generate.
- Lane mux/demux and counter stay in sub_bytes_seq.

Test Plan:
- Identity ramp, forward (LANES=4): in_state=128'h0F0E0D0C0B0A09080706050403020100, in_inv=0 -> after 4 cycles out_state=128'h76ABD7FE2B670130C56F6BF27B777C63, out_valid=1.
- Inverse round-trip: feed the previous result with in_inv=1 -> out_state=128'h0F0E0D0C0B0A09080706050403020100; repeat for LANES=1, 2, 8, 16 with latency 16, 8, 2, 1 respectively.
- Backpressure: all-zero state forward, hold out_ready=0 for 10 cycles -> out_state stays 128'h6363...63, out_valid stays 1, in_ready stays 0; release -> IDLE next edge.
- Back-to-back: in_valid held high with two states; out_ready=1 in DONE -> second state accepted on the same edge as the first output transfer; second result arrives N cycles later; no bubble beyond N+1.
- Mode latch: change in_inv from 0 to 1 during BUSY on a 128'h53 byte pattern -> all output bytes are 8'hED (forward), not inverse.
- Reset mid-BUSY: assert rst at counter=1 (LANES=4) -> next edge in_ready=1, out_valid=0, out_state=0; a following block produces the correct result with no residue.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared definitions: state size, forward/inverse S-box tables, FSM enum.
// Imported by sbox_lut and sub_bytes_seq.
package aes_pkg;

  localparam int NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lut.sv
// Combinational AES S-box lookup, forward or inverse.
// Ports: in_byte (8), inv (0=fwd,1=inv) -> out_byte (8).
module sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: LANES bytes per cycle, valid/ready in and out.
// Ports: clk, rst, in_valid/in_ready/in_state/in_inv,
//        out_valid/out_ready/out_state, busy.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = NBYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                       state_q, state_d;
  logic [NBYTES-1:0][7:0]       work_q, work_d;
  logic [127:0]                 out_q, out_d;
  logic                         inv_q, inv_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic [3:0] base;
  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_out [LANES];

  // First byte of the group handled this cycle.
  assign base = 4'(int'(cnt_q) * LANES);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = base + 4'(l);
    sbox_lut u_sbox (
      .in_byte  (work_q[lane_idx[l]]),
      .inv      (inv_q),
      .out_byte (lane_out[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    out_d     = out_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          work_d[lane_idx[l]] = lane_out[l];
        end
        if (cnt_q == CW'(N - 1)) begin
          out_d   = work_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Output handoff and new input share one edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_state;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_state = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at LANES = 1, 2, 4, 8, 16.
// Scenario tasks check outputs inline against hand-computed values.
module tb_sub_bytes_seq;

  localparam logic [127:0] RAMP =
    128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] RAMP_F =
    128'h76ABD7FE2B670130C56F6BF27B777C63;
  localparam logic [127:0] ZERO_F = {16{8'h63}};
  localparam logic [127:0] PAT53  = {16{8'h53}};
  localparam logic [127:0] PAT53F = {16{8'hED}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;

  logic         ir [5];
  logic         ov [5];
  logic [127:0] os [5];
  logic         bz [5];

  int nvec = 0;
  int nerr = 0;
  int lat_exp [5] = '{16, 8, 4, 2, 1};

  always #5 clk = ~clk;

  sub_bytes_seq #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[0]),
    .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
  sub_bytes_seq #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[1]),
    .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
  sub_bytes_seq #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[2]),
    .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));
  sub_bytes_seq #(.LANES(8)) u_l8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[3]),
    .out_ready(out_ready), .out_state(os[3]), .busy(bz[3]));
  sub_bytes_seq #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]),
    .in_state(in_state), .in_inv(in_inv), .out_valid(ov[4]),
    .out_ready(out_ready), .out_state(os[4]), .busy(bz[4]));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst_all();
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0 ||
          bz[d] !== 1'b0 || os[d] !== 128'h0) begin
        $display("FAIL reset[%0d]: ir=%b ov=%b bz=%b os=%h want 1 0 0 0",
                 d, ir[d], ov[d], bz[d], os[d]);
        nerr++;
      end
    end
  endtask

  // Wait up to 24 edges, recording the edge each DUT raised out_valid.
  task automatic measure(output int lat [5]);
    for (int d = 0; d < 5; d++) lat[d] = 0;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      for (int d = 0; d < 5; d++)
        if (ov[d] === 1'b1 && lat[d] == 0) lat[d] = c;
    end
  endtask

  task automatic test_round_trip();
    int lat [5];
    rst_all();
    in_state = RAMP;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_state = '0;
    measure(lat);
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (lat[d] != lat_exp[d] || os[d] !== RAMP_F) begin
        $display("FAIL fwd_ramp[%0d]: lat=%0d os=%h want %0d %h",
                 d, lat[d], os[d], lat_exp[d], RAMP_F);
        nerr++;
      end
    end
    // All DUTs sit in DONE; hand off and start inverse in one edge.
    in_state  = RAMP_F;
    in_inv    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_inv    = 1'b0;
    measure(lat);
    for (int d = 0; d < 5; d++) begin
      nvec++;
      if (lat[d] != lat_exp[d] || os[d] !== RAMP) begin
        $display("FAIL inv_ramp[%0d]: lat=%0d os=%h want %0d %h",
                 d, lat[d], os[d], lat_exp[d], RAMP);
        nerr++;
      end
    end
  endtask

  task automatic test_backpressure();
    rst_all();
    in_state = '0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    nvec++;
    if (ov[2] !== 1'b1 || os[2] !== ZERO_F) begin
      $display("FAIL bp_first: ov=%b os=%h want 1 %h",
               ov[2], os[2], ZERO_F);
      nerr++;
    end
    for (int c = 0; c < 10; c++) begin
      in_state = RAMP;
      cyc();
      nvec++;
      if (ov[2] !== 1'b1 || ir[2] !== 1'b0 || os[2] !== ZERO_F) begin
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b os=%h want 1 0 %h",
                 c, ov[2], ir[2], os[2], ZERO_F);
        nerr++;
      end
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    nvec++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
      $display("FAIL bp_release: ov=%b ir=%b bz=%b want 0 1 0",
               ov[2], ir[2], bz[2]);
      nerr++;
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    rst_all();
    out_ready = 1'b1;
    in_state  = RAMP;
    in_valid  = 1'b1;
    cyc();
    in_state = '0;
    t1 = 0;
    t2 = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (ov[2] === 1'b1 && t1 == 0) begin
        t1 = c;
        nvec++;
        if (os[2] !== RAMP_F || ir[2] !== 1'b1) begin
          $display("FAIL b2b_first: os=%h ir=%b want %h 1",
                   os[2], ir[2], RAMP_F);
          nerr++;
        end
      end else if (t1 != 0 && c == t1 + 1) begin
        in_valid = 1'b0;
        nvec++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b1) begin
          $display("FAIL b2b_accept: ov=%b bz=%b want 0 1",
                   ov[2], bz[2]);
          nerr++;
        end
      end else if (ov[2] === 1'b1 && t1 != 0 && t2 == 0) begin
        t2 = c;
        nvec++;
        if (os[2] !== ZERO_F) begin
          $display("FAIL b2b_second: os=%h want %h", os[2], ZERO_F);
          nerr++;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nvec++;
    if (t1 != 4 || t2 != 9) begin
      $display("FAIL b2b_timing: t1=%0d t2=%0d want 4 9", t1, t2);
      nerr++;
    end
  endtask

  task automatic test_mode_latch();
    rst_all();
    in_state = PAT53;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_inv   = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    in_inv = 1'b0;
    nvec++;
    if (ov[2] !== 1'b1 || os[2] !== PAT53F) begin
      $display("FAIL mode_latch: ov=%b os=%h want 1 %h",
               ov[2], os[2], PAT53F);
      nerr++;
    end
  endtask

  task automatic test_reset_mid_busy();
    rst_all();
    in_state = PAT53;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nvec++;
    if (ir[2] !== 1'b1 || ov[2] !== 1'b0 ||
        os[2] !== 128'h0 || bz[2] !== 1'b0) begin
      $display("FAIL mid_rst: ir=%b ov=%b bz=%b os=%h want 1 0 0 0",
               ir[2], ov[2], bz[2], os[2]);
      nerr++;
    end
    for (int c = 0; c < 6; c++) begin
      cyc();
      nvec++;
      if (ov[2] !== 1'b0) begin
        $display("FAIL mid_rst_noout[%0d]: ov=%b want 0", c, ov[2]);
        nerr++;
      end
    end
    in_state = RAMP;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    nvec++;
    if (ov[2] !== 1'b1 || os[2] !== RAMP_F) begin
      $display("FAIL mid_rst_next: ov=%b os=%h want 1 %h",
               ov[2], os[2], RAMP_F);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_mode_latch();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
